// File: rtl/id_ex_control_stage.sv
// ID/EX control stage: decodes RV32I instructions into the execute-stage control bundle
// and registers it, inserting load-use bubbles and honouring downstream stall and flush.

package id_ex_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_PASS = 4'd10
    } alu_op_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       is_branch;
        logic       is_jump;
        logic       is_jalr;
    } control_type;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH= 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
endpackage

module id_ex_control_stage
    import id_ex_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr_in,
    input  logic             instr_valid_in,
    input  logic             stall_in,
    input  logic             flush_in,
    output control_type      control_out,
    output logic             control_valid_out,
    output logic [4:0]       rd_out,
    output logic [4:0]       rs1_out,
    output logic [4:0]       rs2_out,
    output logic             illegal_out,
    output logic             stall_out,
    output logic [CNT_W-1:0] bubble_count_out
);
    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t      state, state_next;
    logic [2:0]  flush_cnt, flush_cnt_next;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        alt;
    logic        unused_instr_bits;

    control_type dec_ctrl;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2;
    logic        dec_illegal, use_rs1, use_rs2, writes_rd;

    logic        hazard;
    logic        load_nop, load_dec, count_bubble;

    assign opcode            = instr_in[6:0];
    assign funct3            = instr_in[14:12];
    assign alt               = instr_in[30];
    assign unused_instr_bits = ^{instr_in[31], instr_in[29:25]};

    // funct7[5] selects SUB only where the caller allows it (R-type), SRA for all shifts.
    function automatic alu_op_t alu_from_funct3(input logic [2:0] f3, input logic alt_sel,
                                                input logic sub_ok);
        alu_op_t op;
        unique case (f3)
            3'b000: op = (alt_sel && sub_ok) ? ALU_SUB : ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b101: op = alt_sel ? ALU_SRA : ALU_SRL;
            3'b110: op = ALU_OR;
            3'b111: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first so no latch is inferred.
        dec_ctrl    = '0;
        dec_illegal = 1'b0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        writes_rd   = 1'b0;
        unique case (opcode)
            OPC_R: begin
                dec_ctrl.alu_op    = alu_from_funct3(funct3, alt, 1'b1);
                dec_ctrl.reg_write = 1'b1;
                {use_rs1, use_rs2, writes_rd} = 3'b111;
            end
            OPC_I_ALU: begin
                dec_ctrl.alu_op    = alu_from_funct3(funct3, alt, 1'b0);
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                {use_rs1, writes_rd} = 2'b11;
            end
            OPC_LOAD: begin
                dec_ctrl.alu_op     = ALU_ADD;
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
                dec_ctrl.reg_write  = 1'b1;
                {use_rs1, writes_rd} = 2'b11;
            end
            OPC_STORE: begin
                dec_ctrl.alu_op    = ALU_ADD;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.mem_write = 1'b1;
                {use_rs1, use_rs2} = 2'b11;
            end
            OPC_BRANCH: begin
                dec_ctrl.alu_op    = ALU_SUB;
                dec_ctrl.is_branch = 1'b1;
                {use_rs1, use_rs2} = 2'b11;
            end
            OPC_JAL: begin
                dec_ctrl.is_jump   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                writes_rd          = 1'b1;
            end
            OPC_JALR: begin
                dec_ctrl.alu_op    = ALU_ADD;
                dec_ctrl.is_jump   = 1'b1;
                dec_ctrl.is_jalr   = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                {use_rs1, writes_rd} = 2'b11;
            end
            OPC_LUI: begin
                dec_ctrl.alu_op    = ALU_PASS;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                writes_rd          = 1'b1;
            end
            OPC_AUIPC: begin
                dec_ctrl.alu_op    = ALU_ADD;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                writes_rd          = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign dec_rd  = writes_rd ? instr_in[11:7]  : 5'd0;
    assign dec_rs1 = use_rs1   ? instr_in[19:15] : 5'd0;
    assign dec_rs2 = use_rs2   ? instr_in[24:20] : 5'd0;

    // Unused source indices are already forced to 0 and rd_out is nonzero, so a match implies use.
    assign hazard = control_out.mem_read && control_valid_out && (rd_out != 5'd0) &&
                    instr_valid_in && ((dec_rs1 == rd_out) || (dec_rs2 == rd_out));

    assign stall_out = stall_in || hazard;

    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        load_nop       = 1'b0;
        load_dec       = 1'b0;
        count_bubble   = 1'b0;
        if (flush_in) begin
            load_nop       = 1'b1;
            flush_cnt_next = FLUSH_RELOAD;
            state_next     = (FLUSH_RELOAD != 3'd0) ? ST_FLUSH : ST_RUN;
        end else begin
            unique case (state)
                ST_FLUSH: begin
                    load_nop       = 1'b1;
                    flush_cnt_next = flush_cnt - 3'd1;
                    state_next     = (flush_cnt == 3'd1) ? ST_RUN : ST_FLUSH;
                end
                ST_RUN: begin
                    if (stall_in) begin
                        load_nop = 1'b0;
                    end else if (hazard) begin
                        load_nop     = 1'b1;
                        count_bubble = 1'b1;
                    end else if (instr_valid_in) begin
                        load_dec = 1'b1;
                    end else begin
                        load_nop = 1'b1;
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_RUN;
            flush_cnt <= 3'd0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            control_out       <= '0;
            control_valid_out <= 1'b0;
            rd_out            <= 5'd0;
            rs1_out           <= 5'd0;
            rs2_out           <= 5'd0;
            illegal_out       <= 1'b0;
        end else if (load_nop) begin
            control_out       <= '0;
            control_valid_out <= 1'b0;
            rd_out            <= 5'd0;
            rs1_out           <= 5'd0;
            rs2_out           <= 5'd0;
            illegal_out       <= 1'b0;
        end else if (load_dec) begin
            control_out       <= dec_ctrl;
            control_valid_out <= 1'b1;
            rd_out            <= dec_rd;
            rs1_out           <= dec_rs1;
            rs2_out           <= dec_rs2;
            illegal_out       <= dec_illegal;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_count_out <= '0;
        end else if (count_bubble && (bubble_count_out != '1)) begin
            bubble_count_out <= bubble_count_out + 1'b1;
        end
    end
endmodule

// File: tb/tb_id_ex_control_stage.sv
// Self-checking bench for id_ex_control_stage: decode vector table, hand-written hazard,
// stall, flush and reset sequences, then random traffic against a behavioural model.

module tb_id_ex_control_stage;
    import id_ex_pkg::*;

    localparam int FLUSH_CYCLES = 3;
    localparam int CNT_W        = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      instr_in;
    logic             instr_valid_in, stall_in, flush_in;
    control_type      control_out;
    logic             control_valid_out, illegal_out, stall_out;
    logic [4:0]       rd_out, rs1_out, rs2_out;
    logic [CNT_W-1:0] bubble_count_out;

    id_ex_control_stage #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .instr_in         (instr_in),
        .instr_valid_in   (instr_valid_in),
        .stall_in         (stall_in),
        .flush_in         (flush_in),
        .control_out      (control_out),
        .control_valid_out(control_valid_out),
        .rd_out           (rd_out),
        .rs1_out          (rs1_out),
        .rs2_out          (rs2_out),
        .illegal_out      (illegal_out),
        .stall_out        (stall_out),
        .bubble_count_out (bubble_count_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic last_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam logic [3:0] ALU_OF_F3 [0:7] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

    control_type m_ctrl;
    logic        m_valid, m_ill;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    int          m_flush_left, m_bub;

    function automatic void ref_decode(input logic [31:0] ins, output control_type c,
                                       output logic [4:0] rd, output logic [4:0] rs1,
                                       output logic [4:0] rs2, output logic ill);
        logic [2:0] f3;
        logic alt, u1, u2, w;
        f3 = ins[14:12];
        alt = ins[30];
        c = '0; ill = 1'b0; u1 = 1'b0; u2 = 1'b0; w = 1'b0;
        case (ins[6:0])
            7'h33: begin
                c.alu_op = (alt && f3 == 3'd0) ? 4'd1 : (alt && f3 == 3'd5) ? 4'd7 : ALU_OF_F3[f3];
                c.reg_write = 1'b1; u1 = 1'b1; u2 = 1'b1; w = 1'b1;
            end
            7'h13: begin
                c.alu_op = (alt && f3 == 3'd5) ? 4'd7 : ALU_OF_F3[f3];
                c.alu_src = 1'b1; c.reg_write = 1'b1; u1 = 1'b1; w = 1'b1;
            end
            7'h03: begin
                c.alu_src = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.reg_write = 1'b1;
                u1 = 1'b1; w = 1'b1;
            end
            7'h23: begin c.alu_src = 1'b1; c.mem_write = 1'b1; u1 = 1'b1; u2 = 1'b1; end
            7'h63: begin c.alu_op = 4'd1; c.is_branch = 1'b1; u1 = 1'b1; u2 = 1'b1; end
            7'h6F: begin c.is_jump = 1'b1; c.reg_write = 1'b1; w = 1'b1; end
            7'h67: begin
                c.is_jump = 1'b1; c.is_jalr = 1'b1; c.alu_src = 1'b1; c.reg_write = 1'b1;
                u1 = 1'b1; w = 1'b1;
            end
            7'h37: begin c.alu_op = 4'd10; c.alu_src = 1'b1; c.reg_write = 1'b1; w = 1'b1; end
            7'h17: begin c.alu_src = 1'b1; c.reg_write = 1'b1; w = 1'b1; end
            default: ill = 1'b1;
        endcase
        rd  = w  ? ins[11:7]  : 5'd0;
        rs1 = u1 ? ins[19:15] : 5'd0;
        rs2 = u2 ? ins[24:20] : 5'd0;
    endfunction

    task automatic model_nop();
        m_ctrl = '0; m_valid = 1'b0; m_ill = 1'b0;
        m_rd = 5'd0; m_rs1 = 5'd0; m_rs2 = 5'd0;
    endtask

    task automatic model_reset();
        model_nop();
        m_flush_left = 0;
        m_bub = 0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, " control"}, 32'(control_out), 32'(m_ctrl));
        check({tag, " valid"},   32'(control_valid_out), 32'(m_valid));
        check({tag, " rd"},      32'(rd_out), 32'(m_rd));
        check({tag, " rs1"},     32'(rs1_out), 32'(m_rs1));
        check({tag, " rs2"},     32'(rs2_out), 32'(m_rs2));
        check({tag, " illegal"}, 32'(illegal_out), 32'(m_ill));
        check({tag, " bubbles"}, 32'(bubble_count_out), 32'(m_bub));
    endtask

    // Drives one cycle of inputs, checks stall_out, advances the model, checks registers.
    task automatic step(input logic [31:0] ins, input logic v, input logic st, input logic fl,
                        input string tag);
        control_type dc;
        logic [4:0] drd, drs1, drs2;
        logic dill, haz;
        instr_in = ins; instr_valid_in = v; stall_in = st; flush_in = fl;
        #1;
        ref_decode(ins, dc, drd, drs1, drs2, dill);
        haz = m_ctrl.mem_read && m_valid && (m_rd != 5'd0) && v &&
              ((drs1 == m_rd) || (drs2 == m_rd));
        last_stall = stall_out;
        check({tag, " stall_out"}, 32'(stall_out), 32'(st | haz));
        if (fl) begin
            model_nop(); m_flush_left = FLUSH_CYCLES - 1;
        end else if (m_flush_left > 0) begin
            model_nop(); m_flush_left--;
        end else if (st) begin
            m_ctrl = m_ctrl;
        end else if (haz) begin
            model_nop();
            if (m_bub < (1 << CNT_W) - 1) m_bub++;
        end else if (v) begin
            m_ctrl = dc; m_valid = 1'b1; m_rd = drd; m_rs1 = drs1; m_rs2 = drs2; m_ill = dill;
        end else begin
            model_nop();
        end
        @(posedge clk);
        #1;
        check_regs(tag);
    endtask

    // ---------------- decode vector table ----------------
    typedef struct {
        logic [31:0] instr;
        logic [3:0]  alu_op;
        logic [7:0]  flags;   // alu_src mem_read mem_write reg_write mem_to_reg is_branch is_jump is_jalr
        logic [4:0]  rd, rs1, rs2;
        logic        ill;
    } vec_t;

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic vec_t mk(input logic [31:0] i, input logic [3:0] a, input logic [7:0] f,
                                input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                                input logic il);
        vec_t v;
        v.instr = i; v.alu_op = a; v.flags = f; v.rd = d; v.rs1 = s1; v.rs2 = s2; v.ill = il;
        return v;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [0:9];
        logic [6:0] f7;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
        f7 = {1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31))};
        return enc(f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)),
                   ops[$urandom_range(0, 9)]);
    endfunction

    localparam logic [31:0] ADD_X3    = 32'h002081B3;
    localparam logic [31:0] SUB_X7    = 32'h402083B3;
    localparam logic [31:0] LW_X5     = 32'h0000A283;
    localparam logic [31:0] ADD_X6_X5 = 32'h00228333;
    localparam logic [31:0] LW_X0     = 32'h00008003;
    localparam logic [31:0] ADD_X6_X0 = 32'h00200333;
    localparam logic [31:0] JAL_F5    = 32'h000280EF;
    localparam logic [31:0] LW_X5_X5  = 32'h0002A283;

    vec_t vecs[$];
    control_type exp_sub;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_sub = '0;
        exp_sub.alu_op = 4'd1;
        exp_sub.reg_write = 1'b1;

        vecs.push_back(mk(ADD_X3,                         4'd0,  8'b0001_0000, 5'd3, 5'd1, 5'd2, 1'b0));
        vecs.push_back(mk(SUB_X7,                         4'd1,  8'b0001_0000, 5'd7, 5'd1, 5'd2, 1'b0));
        vecs.push_back(mk(enc(7'h00, 4, 3, 3'd1, 8, 7'h33), 4'd2, 8'b0001_0000, 5'd8, 5'd3, 5'd4, 1'b0));
        vecs.push_back(mk(enc(7'h00, 4, 3, 3'd2, 8, 7'h33), 4'd3, 8'b0001_0000, 5'd8, 5'd3, 5'd4, 1'b0));
        vecs.push_back(mk(enc(7'h00, 4, 3, 3'd3, 8, 7'h33), 4'd4, 8'b0001_0000, 5'd8, 5'd3, 5'd4, 1'b0));
        vecs.push_back(mk(enc(7'h00, 4, 3, 3'd4, 8, 7'h33), 4'd5, 8'b0001_0000, 5'd8, 5'd3, 5'd4, 1'b0));
        vecs.push_back(mk(enc(7'h00, 4, 3, 3'd5, 8, 7'h33), 4'd6, 8'b0001_0000, 5'd8, 5'd3, 5'd4, 1'b0));
        vecs.push_back(mk(enc(7'h20, 4, 3, 3'd5, 8, 7'h33), 4'd7, 8'b0001_0000, 5'd8, 5'd3, 5'd4, 1'b0));
        vecs.push_back(mk(enc(7'h00, 4, 3, 3'd6, 8, 7'h33), 4'd8, 8'b0001_0000, 5'd8, 5'd3, 5'd4, 1'b0));
        vecs.push_back(mk(enc(7'h00, 4, 3, 3'd7, 8, 7'h33), 4'd9, 8'b0001_0000, 5'd8, 5'd3, 5'd4, 1'b0));
        vecs.push_back(mk(enc(7'h20, 9, 1, 3'd0, 4, 7'h13), 4'd0, 8'b1001_0000, 5'd4, 5'd1, 5'd0, 1'b0));
        vecs.push_back(mk(enc(7'h20, 3, 1, 3'd5, 4, 7'h13), 4'd7, 8'b1001_0000, 5'd4, 5'd1, 5'd0, 1'b0));
        vecs.push_back(mk(enc(7'h00, 3, 1, 3'd5, 4, 7'h13), 4'd6, 8'b1001_0000, 5'd4, 5'd1, 5'd0, 1'b0));
        vecs.push_back(mk(enc(7'h00, 3, 1, 3'd1, 4, 7'h13), 4'd2, 8'b1001_0000, 5'd4, 5'd1, 5'd0, 1'b0));
        vecs.push_back(mk(enc(7'h00, 3, 1, 3'd7, 4, 7'h13), 4'd9, 8'b1001_0000, 5'd4, 5'd1, 5'd0, 1'b0));
        vecs.push_back(mk(enc(7'h00, 4, 1, 3'd2, 5, 7'h03), 4'd0, 8'b1101_1000, 5'd5, 5'd1, 5'd0, 1'b0));
        vecs.push_back(mk(enc(7'h00, 2, 1, 3'd2, 4, 7'h23), 4'd0, 8'b1010_0000, 5'd0, 5'd1, 5'd2, 1'b0));
        vecs.push_back(mk(enc(7'h00, 2, 1, 3'd0, 8, 7'h63), 4'd1, 8'b0000_0100, 5'd0, 5'd1, 5'd2, 1'b0));
        vecs.push_back(mk(enc(7'h20, 2, 1, 3'd1, 8, 7'h63), 4'd1, 8'b0000_0100, 5'd0, 5'd1, 5'd2, 1'b0));
        vecs.push_back(mk(32'h00AF80EF,                   4'd0,  8'b0001_0010, 5'd1, 5'd0, 5'd0, 1'b0));
        vecs.push_back(mk(32'h003280E7,                   4'd0,  8'b1001_0011, 5'd1, 5'd5, 5'd0, 1'b0));
        vecs.push_back(mk(32'h123454B7,                   4'd10, 8'b1001_0000, 5'd9, 5'd0, 5'd0, 1'b0));
        vecs.push_back(mk(32'h00001517,                   4'd0,  8'b1001_0000, 5'd10, 5'd0, 5'd0, 1'b0));
        vecs.push_back(mk(32'h0000007F,                   4'd0,  8'b0000_0000, 5'd0, 5'd0, 5'd0, 1'b1));
        vecs.push_back(mk(32'hFFFFFFFF,                   4'd0,  8'b0000_0000, 5'd0, 5'd0, 5'd0, 1'b1));

        reset = 1'b1;
        instr_in = '0; instr_valid_in = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_regs("reset");
        check("reset stall_out", 32'(stall_out), 32'd0);
        reset = 1'b0;

        // add x3,x1,x2 decodes one edge later
        step(ADD_X3, 1'b1, 1'b0, 1'b0, "add");
        check("add alu_op", 32'(control_out.alu_op), 32'd0);
        check("add rd", 32'(rd_out), 32'd3);

        // load-use: one stall cycle, one bubble, consumer follows
        step(LW_X5, 1'b1, 1'b0, 1'b0, "lw");
        step(ADD_X6_X5, 1'b1, 1'b0, 1'b0, "use");
        check("hazard stall", 32'(last_stall), 32'd1);
        check("bubble valid", 32'(control_valid_out), 32'd0);
        check("bubble count", 32'(bubble_count_out), 32'd1);
        step(ADD_X6_X5, 1'b1, 1'b0, 1'b0, "use2");
        check("after bubble stall", 32'(last_stall), 32'd0);
        check("after bubble rd", 32'(rd_out), 32'd6);

        // x0 destination never stalls; unused rs1 field never stalls
        step(LW_X0, 1'b1, 1'b0, 1'b0, "lw x0");
        step(ADD_X6_X0, 1'b1, 1'b0, 1'b0, "use x0");
        check("x0 no stall", 32'(last_stall), 32'd0);
        step(LW_X5, 1'b1, 1'b0, 1'b0, "lw x5b");
        step(JAL_F5, 1'b1, 1'b0, 1'b0, "jal");
        check("jal no stall", 32'(last_stall), 32'd0);
        check("no extra bubbles", 32'(bubble_count_out), 32'd1);

        foreach (vecs[i]) begin
            step(32'h0, 1'b0, 1'b0, 1'b0, "idle");
            step(vecs[i].instr, 1'b1, 1'b0, 1'b0, "vec");
            check($sformatf("vec%0d alu_op", i), 32'(control_out.alu_op), 32'(vecs[i].alu_op));
            check($sformatf("vec%0d flags", i), 32'(control_out[7:0]), 32'(vecs[i].flags));
            check($sformatf("vec%0d rd", i), 32'(rd_out), 32'(vecs[i].rd));
            check($sformatf("vec%0d rs1", i), 32'(rs1_out), 32'(vecs[i].rs1));
            check($sformatf("vec%0d rs2", i), 32'(rs2_out), 32'(vecs[i].rs2));
            check($sformatf("vec%0d illegal", i), 32'(illegal_out), 32'(vecs[i].ill));
            check($sformatf("vec%0d valid", i), 32'(control_valid_out), 32'd1);
        end

        // flush with valid instructions streaming: three NOP cycles then decode
        step(ADD_X3, 1'b1, 1'b0, 1'b0, "pre flush");
        step(ADD_X3, 1'b1, 1'b0, 1'b1, "flush");
        check("flush nop0", 32'(control_valid_out), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step(ADD_X3, 1'b1, 1'b0, 1'b0, "flushing");
            check($sformatf("flush nop%0d", i + 1), 32'(control_valid_out), 32'd0);
        end
        step(ADD_X3, 1'b1, 1'b0, 1'b0, "post flush");
        check("post flush valid", 32'(control_valid_out), 32'd1);

        // downstream stall holds everything, then flush beats stall
        step(SUB_X7, 1'b1, 1'b0, 1'b0, "sub");
        for (int i = 0; i < 4; i++) begin
            step(ADD_X3, 1'b1, 1'b1, 1'b0, "held");
            check($sformatf("held%0d control", i), 32'(control_out), 32'(exp_sub));
            check($sformatf("held%0d rd", i), 32'(rd_out), 32'd7);
        end
        step(ADD_X3, 1'b1, 1'b1, 1'b1, "flush+stall");
        check("flush+stall control", 32'(control_out), 32'd0);
        check("flush+stall valid", 32'(control_valid_out), 32'd0);

        // asynchronous reset in the middle of a flush window
        step(ADD_X3, 1'b1, 1'b0, 1'b0, "rf pre");
        step(ADD_X3, 1'b1, 1'b0, 1'b1, "rf flush");
        #2;
        reset = 1'b1;
        #1;
        check("async rst control", 32'(control_out), 32'd0);
        check("async rst valid", 32'(control_valid_out), 32'd0);
        check("async rst bubbles", 32'(bubble_count_out), 32'd0);
        check("async rst rd", 32'(rd_out), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(ADD_X3, 1'b1, 1'b0, 1'b0, "after rst");
        check("after rst decodes", 32'(control_valid_out), 32'd1);

        for (int i = 0; i < 400; i++) begin
            step(rand_instr(), 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 15) == 0), "rand");
        end

        // saturation of the bubble counter
        for (int i = 0; i < 40; i++) begin
            step(LW_X5_X5, 1'b1, 1'b0, 1'b0, "sat");
        end
        check("bubble saturated", 32'(bubble_count_out), 32'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
